// File: rtl/dense_layer_param_mac.sv
// Fully-connected layer engine: pulls the upstream activation vector, runs one MAC per neuron
// against streamed weight/bias ROMs, then requantises, activates, saturates and tracks argmax.
module dense_layer_param_mac #(
    parameter int unsigned IN_DIM   = 128,
    parameter int unsigned OUT_DIM  = 9,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned W_W      = 8,
    parameter int unsigned B_W      = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned ACT_MODE = 0,
    parameter int unsigned SHIFT6   = 0,
    localparam int unsigned PA_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    localparam int unsigned WA_W    = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1,
    localparam int unsigned OA_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             prev_start,
    input  logic             prev_done,
    output logic [PA_W-1:0]  prev_addr,
    input  logic [IN_W-1:0]  prev_data,
    output logic [WA_W-1:0]  weight_addr,
    input  logic [W_W-1:0]   weight_data,
    output logic [OA_W-1:0]  bias_addr,
    input  logic [B_W-1:0]   bias_data,
    input  logic [OA_W-1:0]  read_addr,
    output logic [OUT_W-1:0] read_data,
    output logic [OA_W-1:0]  argmax_idx
);

    localparam int unsigned CNT_W = $clog2(IN_DIM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_DIM);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(IN_DIM - 1);
    localparam logic [OA_W-1:0] O_LAST = OA_W'(OUT_DIM - 1);
    localparam logic [OA_W:0] OUT_DIM_X = (OA_W + 1)'(OUT_DIM);
    localparam logic signed [ACC_W-1:0] RELU6_MAX = ACC_W'(6 << SHIFT6);
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    if (IN_DIM < 1 || OUT_DIM < 1 || OUT_W > ACC_W) begin : g_bad_params
        $error("dense_layer_param_mac: need IN_DIM>=1, OUT_DIM>=1 and OUT_W<=ACC_W");
    end

    typedef enum logic [2:0] {StIdle, StWaitPrev, StLoadIn, StBias, StMac, StPost, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d, prev_start_q, prev_start_d;
    logic [PA_W-1:0]         prev_addr_q, prev_addr_d;
    logic [WA_W-1:0]         weight_addr_q, weight_addr_d;
    logic [OA_W-1:0]         o_q, o_d, argmax_q, argmax_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] best_q, best_d;
    logic signed [IN_W-1:0]  in_buf_q [IN_DIM];
    logic signed [IN_W-1:0]  in_buf_d [IN_DIM];
    logic signed [OUT_W-1:0] out_mem_q [OUT_DIM];
    logic signed [OUT_W-1:0] out_mem_d [OUT_DIM];

    logic [PA_W-1:0]             buf_idx;
    logic signed [W_W+IN_W-1:0]  prod;
    logic signed [ACC_W-1:0]     shifted, act, sat;
    logic signed [OUT_W-1:0]     post_val;

    // Data for address k arrives one cycle later, so buffer slot and MAC operand lag cnt by one.
    assign buf_idx = PA_W'(cnt_q - 1'b1);
    assign prod = $signed(weight_data) * in_buf_q[buf_idx];

    always_comb begin
        shifted = acc_q >>> SHIFT;
        act = shifted;
        if ((ACT_MODE == 1 || ACT_MODE == 2) && shifted < 0) begin
            act = '0;
        end
        if (ACT_MODE == 2 && shifted > RELU6_MAX) begin
            act = RELU6_MAX;
        end
        if (act > OUT_MAX) begin
            sat = OUT_MAX;
        end else if (act < OUT_MIN) begin
            sat = OUT_MIN;
        end else begin
            sat = act;
        end
        post_val = sat[OUT_W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        prev_start_d  = 1'b0;
        prev_addr_d   = prev_addr_q;
        weight_addr_d = weight_addr_q;
        o_d           = o_q;
        argmax_d      = argmax_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        best_d        = best_q;
        in_buf_d      = in_buf_q;
        out_mem_d     = out_mem_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StWaitPrev;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    prev_start_d = 1'b1;
                end
            end
            StWaitPrev: begin
                if (prev_done) begin
                    state_d     = StLoadIn;
                    cnt_d       = '0;
                    prev_addr_d = '0;
                end
            end
            StLoadIn: begin
                if (cnt_q != '0) begin
                    in_buf_d[buf_idx] = prev_data;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d       = StBias;
                    o_d           = '0;
                    weight_addr_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < CNT_PRE) begin
                        prev_addr_d = prev_addr_q + 1'b1;
                    end
                end
            end
            StBias: begin
                state_d = StMac;
                cnt_d   = '0;
            end
            StMac: begin
                if (cnt_q == '0) begin
                    acc_d = ACC_W'($signed(bias_data));
                end else begin
                    acc_d = acc_q + ACC_W'(prod);
                end
                // Address runs one ahead of the product consuming it.
                if (cnt_q < CNT_PRE) begin
                    weight_addr_d = weight_addr_q + 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = StPost;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPost: begin
                out_mem_d[o_q] = post_val;
                if (o_q == '0 || post_val > best_q) begin
                    best_d   = post_val;
                    argmax_d = o_q;
                end
                if (o_q == O_LAST) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d       = StBias;
                    o_d           = o_q + 1'b1;
                    weight_addr_d = weight_addr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            prev_start_q  <= 1'b0;
            prev_addr_q   <= '0;
            weight_addr_q <= '0;
            o_q           <= '0;
            argmax_q      <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            best_q        <= '0;
            in_buf_q      <= '{default: '0};
            out_mem_q     <= '{default: '0};
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            prev_start_q  <= prev_start_d;
            prev_addr_q   <= prev_addr_d;
            weight_addr_q <= weight_addr_d;
            o_q           <= o_d;
            argmax_q      <= argmax_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            best_q        <= best_d;
            in_buf_q      <= in_buf_d;
            out_mem_q     <= out_mem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign prev_start  = prev_start_q;
    assign prev_addr   = prev_addr_q;
    assign weight_addr = weight_addr_q;
    assign bias_addr   = o_q;
    assign argmax_idx  = argmax_q;
    assign read_data   = ({1'b0, read_addr} < OUT_DIM_X) ? out_mem_q[read_addr] : '0;

endmodule
